// File: rtl/sdram_bridge_pkg.sv
// Shared types for the Wishbone-to-SDRAM bridge: FSM state encoding,
// default address window and the byte-lane merge used by read-modify-write.
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    MERGE   = 3'd3,
    WR_REQ  = 3'd4,
    ACK     = 3'd5
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFF80_0000;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  sel
  );
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) m[8*i +: 8] = nw[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sdram_wb_bridge_if.sv
// Wishbone classic bus between the user-project master and the bridge.
// master: drives cyc/stb/we/sel/adr/dat_i; slave: drives ack/dat_o.
interface sdram_wb_bridge_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/sdram_wb_bridge.sv
// Wishbone slave -> SDRAM controller user port; one request per bus cycle,
// RMW for partial writes. Ports: clk, rst (sync, high), wb (slave), ctrl side.
module sdram_wb_bridge
  import sdram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK
) (
  input  logic             clk,
  input  logic             rst,
  sdram_wb_bridge_if.slave wb,
  output logic [22:0]      user_addr,
  output logic             rw,
  output logic [31:0]      data_in,
  output logic             in_valid,
  input  logic             busy,
  input  logic [31:0]      data_out,
  input  logic             out_valid
);

  state_t      state, state_d;
  logic [22:0] addr_d;
  logic        rw_d, iv_d;
  logic        ack_q, ack_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] din_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        rmw_q, rmw_d;
  logic        skip_q;
  logic        hit, req, take;

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dout_q;

  assign hit = (wb.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign req = wb.wbs_cyc_i & wb.wbs_stb_i
             & hit & ~ack_q;

  // read data is not trusted during the pulse or the cycle right after it
  assign take = out_valid & ~in_valid & ~skip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      user_addr <= '0;
      rw        <= 1'b0;
      in_valid  <= 1'b0;
      ack_q     <= 1'b0;
      dout_q    <= '0;
      data_in   <= '0;
      buf_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rmw_q     <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state     <= state_d;
      user_addr <= addr_d;
      rw        <= rw_d;
      in_valid  <= iv_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
      data_in   <= din_d;
      buf_q     <= buf_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rmw_q     <= rmw_d;
      skip_q    <= in_valid;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = user_addr;
    rw_d    = 1'b0;
    iv_d    = 1'b0;
    ack_d   = 1'b0;
    dout_d  = dout_q;
    din_d   = data_in;
    buf_d   = buf_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rmw_d   = rmw_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          addr_d = {wb.wbs_adr_i[22:2], 2'b00};
          dat_d  = wb.wbs_dat_i;
          sel_d  = wb.wbs_sel_i;
          rmw_d  = 1'b0;
          if (!wb.wbs_we_i) begin
            state_d = RD_REQ;
          end else if (wb.wbs_sel_i == 4'hF) begin
            din_d   = wb.wbs_dat_i;
            state_d = WR_REQ;
          end else if (wb.wbs_sel_i == 4'h0) begin
            state_d = ACK;
          end else begin
            rmw_d   = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!busy) begin
          iv_d    = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (take) begin
          buf_d = data_out;
          // abandoned cycle: drop the data and skip the RMW write
          if (!wb.wbs_cyc_i) begin
            state_d = IDLE;
          end else if (rmw_q) begin
            state_d = MERGE;
          end else begin
            dout_d  = data_out;
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      MERGE: begin
        din_d   = merge_bytes(buf_q, dat_q, sel_q);
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (!busy) begin
          iv_d    = 1'b1;
          rw_d    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        // reads enter with ack already raised
        ack_d   = wb.wbs_cyc_i & ~ack_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Self-checking bench for sdram_wb_bridge with a small SDRAM controller
// model and scoreboard queues for controller requests and bus acks.
module tb_sdram_wb_bridge;
  import sdram_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_wb_bridge_if wb();

  logic [22:0] user_addr;
  logic        rw, in_valid, out_valid;
  logic [31:0] data_in, data_out;
  logic        busy, busy_main, busy_ov;
  assign busy = busy_main | busy_ov;

  sdram_wb_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .user_addr (user_addr),
    .rw        (rw),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .busy      (busy),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  typedef struct {
    logic        rw;
    logic [22:0] addr;
    logic [31:0] data;
  } req_t;
  typedef struct {
    logic        rd;
    logic [31:0] data;
  } ack_t;

  req_t exp_req[$];
  ack_t exp_ack[$];
  req_t er;
  ack_t ea;
  logic [31:0] mem [logic [22:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int iv_cnt  = 0;
  int ack_cnt = 0;
  int iv_cyc  = 0;
  int ov_cyc  = 0;
  int rd_cnt  = 0;
  int glitch_at = -1;
  logic [22:0] rd_addr;
  logic glitch_en, busy_ov_en;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // controller model + scoreboard pop, all sampled mid-cycle
  always @(negedge clk) begin
    out_valid = 1'b0;
    busy_ov   = 1'b0;
    if (rst) begin
      rd_cnt    = 0;
      glitch_at = -1;
    end
    if (glitch_at == cyc_n) begin
      out_valid = 1'b1;
      data_out  = 32'hDEAD_BEEF;
    end
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        out_valid = 1'b1;
        data_out  = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
        ov_cyc    = cyc_n;
        busy_ov   = busy_ov_en;
      end
    end
    if (in_valid) begin
      iv_cnt++;
      iv_cyc = cyc_n;
      if (glitch_en) glitch_at = cyc_n + 1;
      if (rw) begin
        mem[user_addr] = data_in;
      end else begin
        rd_cnt  = 6;
        rd_addr = user_addr;
      end
      if (exp_req.size() == 0) begin
        check("req_unexp", 32'd1, 32'd0);
      end else begin
        er = exp_req.pop_front();
        check("req_rw", {31'd0, rw}, {31'd0, er.rw});
        check("req_addr", {9'd0, user_addr}, {9'd0, er.addr});
        if (er.rw) check("req_data", data_in, er.data);
      end
    end
    if (wb.wbs_ack_o) begin
      ack_cnt++;
      if (exp_ack.size() == 0) begin
        check("ack_unexp", 32'd1, 32'd0);
      end else begin
        ea = exp_ack.pop_front();
        if (ea.rd) begin
          check("rd_data", wb.wbs_dat_o, ea.data);
          check("rd_ack_lat", 32'(cyc_n - ov_cyc), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_req(input logic r, input logic [22:0] a,
                          input logic [31:0] d);
    req_t t;
    t.rw = r; t.addr = a; t.data = d;
    exp_req.push_back(t);
  endtask

  task automatic push_ack(input logic r, input logic [31:0] d);
    ack_t t;
    t.rd = r; t.data = d;
    exp_ack.push_back(t);
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_sel_i = sel;
  endtask

  task automatic wb_stop();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input int budget,
                         output logic acked, output int lat);
    wb_start(we, adr, dat, sel);
    acked = 1'b0;
    lat   = 0;
    for (int i = 0; i < budget && !acked; i++) begin
      tick();
      lat++;
      if (wb.wbs_ack_o) acked = 1'b1;
    end
    wb_stop();
  endtask

  logic        acked, acked2;
  int          lat, lat2, n0, a0, rel;
  logic [31:0] dat0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    busy_main  = 1'b0;
    glitch_en  = 1'b0;
    busy_ov_en = 1'b0;
    data_out   = '0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = '0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    mem[23'h20] = 32'h1122_3344;
    repeat (3) tick();
    check("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    check("rst_dat", wb.wbs_dat_o, 32'd0);
    check("rst_iv", {31'd0, in_valid}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd0);
    check("rst_addr", {9'd0, user_addr}, 32'd0);
    check("rst_din", data_in, 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    tick();

    push_req(1'b1, 23'h10, 32'hA5A5_1234);
    push_ack(1'b0, 32'h0);
    wb_xfer(1'b1, 32'h3800_0010, 32'hA5A5_1234, 4'hF, 20, acked, lat);
    check("wr_ack", {31'd0, acked}, 32'd1);
    check("wr_lat", 32'(lat), 32'd3);
    tick();

    glitch_en  = 1'b1;
    busy_ov_en = 1'b1;
    push_req(1'b0, 23'h10, 32'h0);
    push_ack(1'b1, 32'hA5A5_1234);
    wb_xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, 40, acked, lat);
    check("rd_ack", {31'd0, acked}, 32'd1);
    glitch_en  = 1'b0;
    busy_ov_en = 1'b0;
    tick();

    push_req(1'b0, 23'h20, 32'h0);
    push_req(1'b1, 23'h20, 32'h11BB_33DD);
    push_ack(1'b0, 32'h0);
    n0 = iv_cnt;
    wb_xfer(1'b1, 32'h3800_0020, 32'hAABB_CCDD, 4'b0101, 60, acked, lat);
    check("rmw_ack", {31'd0, acked}, 32'd1);
    check("rmw_iv", 32'(iv_cnt - n0), 32'd2);
    check("rmw_mem", mem[23'h20], 32'h11BB_33DD);
    tick();

    push_ack(1'b0, 32'h0);
    n0 = iv_cnt;
    wb_xfer(1'b1, 32'h3800_0030, 32'h5555_5555, 4'h0, 20, acked, lat);
    check("sel0_ack", {31'd0, acked}, 32'd1);
    check("sel0_lat", 32'(lat), 32'd2);
    check("sel0_no_iv", 32'(iv_cnt - n0), 32'd0);
    tick();

    busy_main = 1'b1;
    push_req(1'b0, 23'h20, 32'h0);
    push_ack(1'b1, 32'h11BB_33DD);
    n0 = iv_cnt;
    fork
      wb_xfer(1'b0, 32'h3800_0020, 32'h0, 4'hF, 80, acked, lat);
      begin
        repeat (20) tick();
        check("stall_no_iv", 32'(iv_cnt - n0), 32'd0);
        rel = cyc_n;
        busy_main = 1'b0;
      end
    join
    check("stall_ack", {31'd0, acked}, 32'd1);
    check("stall_one_iv", 32'(iv_cnt - n0), 32'd1);
    check("stall_iv_after", {31'd0, iv_cyc > rel}, 32'd1);
    tick();

    n0 = iv_cnt;
    a0 = ack_cnt;
    wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 50, acked, lat);
    check("miss_ack", {31'd0, acked}, 32'd0);
    check("miss_iv", 32'(iv_cnt - n0), 32'd0);
    tick();

    push_req(1'b1, 23'h100, 32'h0BAD_F00D);
    push_ack(1'b0, 32'h0);
    push_req(1'b1, 23'h104, 32'hCAFE_0104);
    push_ack(1'b0, 32'h0);
    wb_xfer(1'b1, 32'h3800_0100, 32'h0BAD_F00D, 4'hF, 20, acked, lat);
    wb_xfer(1'b1, 32'h3800_0104, 32'hCAFE_0104, 4'hF, 20, acked2, lat2);
    check("b2b_ack0", {31'd0, acked}, 32'd1);
    check("b2b_ack1", {31'd0, acked2}, 32'd1);
    tick();

    push_req(1'b0, 23'h10, 32'h0);
    n0   = iv_cnt;
    a0   = ack_cnt;
    dat0 = wb.wbs_dat_o;
    wb_start(1'b0, 32'h3800_0010, 32'h0, 4'hF);
    for (int i = 0; i < 20 && iv_cnt == n0; i++) tick();
    check("abort_iv", 32'(iv_cnt - n0), 32'd1);
    tick();
    wb_stop();
    repeat (12) tick();
    check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("abort_dat", wb.wbs_dat_o, dat0);
    check("abort_idle", 32'(dut.state), 32'(IDLE));

    push_req(1'b0, 23'h104, 32'h0);
    push_ack(1'b1, 32'hCAFE_0104);
    wb_xfer(1'b0, 32'h3800_0104, 32'h0, 4'hF, 40, acked, lat);
    check("post_abort_ack", {31'd0, acked}, 32'd1);
    tick();

    busy_main = 1'b1;
    n0 = iv_cnt;
    wb_start(1'b1, 32'h3800_0200, 32'h0000_0001, 4'hF);
    repeat (3) tick();
    check("wrq_state", 32'(dut.state), 32'(WR_REQ));
    rst = 1'b1;
    tick();
    check("rst_mid_iv", {31'd0, in_valid}, 32'd0);
    check("rst_mid_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    busy_main = 1'b0;
    wb_stop();
    repeat (5) tick();
    check("rst_mid_no_iv", 32'(iv_cnt - n0), 32'd0);

    check("req_q_empty", 32'(exp_req.size()), 32'd0);
    check("ack_q_empty", 32'(exp_ack.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_wb_bridge.md
# sdram_wb_bridge

Wishbone classic slave that turns bus cycles from the user-project Wishbone port into single requests on the SDRAM controller's user interface (`user_addr`/`rw`/`in_valid`/`busy`/`out_valid`). It sits directly upstream of `sdram_controller`, owns address-window decode and the request/response handshake, and performs read-modify-write for partial-byte writes. The controller has no byte-mask path, because `sdram_dqm` is held at 0.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h3800_0000`: base byte address of the SDRAM window.
- `ADDR_MASK`, default `32'hFF80_0000`: a bus address hits when `(wbs_adr_i & ADDR_MASK) == BASE_ADDR`. This gives an 8 MB window.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `wbs_cyc_i` in 1 — bus cycle.
- `wbs_stb_i` in 1 — strobe.
- `wbs_we_i` in 1 — 1 = write.
- `wbs_sel_i` in 4 — byte enables.
- `wbs_adr_i` in 32 — byte address.
- `wbs_dat_i` in 32 — write data.
- `wbs_ack_o` out 1 — one-cycle acknowledge.
- `wbs_dat_o` out 32 — read data, registered.
- `user_addr` out 23 — equals `{wbs_adr_i[22:2], 2'b00}`, latched at request capture.
- `rw` out 1 — 1 = write, to the controller.
- `data_in` out 32 — write data to the controller.
- `in_valid` out 1 — one-cycle request pulse.
- `busy` in 1 — controller cannot accept a request.
- `data_out` in 32 — controller read data.
- `out_valid` in 1 — controller read-data strobe.

## Operation
- States: `IDLE`, `RD_REQ`, `RD_WAIT`, `MERGE`, `WR_REQ`, `ACK`.
- **Capture in IDLE.** On `wbs_cyc_i & wbs_stb_i & hit & !wbs_ack_o`, latch the address, `we`, `sel` and data.
  - Read → `RD_REQ`.
  - Write with `sel == 4'hF` → `WR_REQ`.
  - Write with `sel != 4'hF` → `RD_REQ`, with the `rmw` flag set.
  - Write with `sel == 4'h0` → `ACK` directly. No SDRAM access.
- **Miss.** An address outside the window is ignored: no ack, and the FSM stays in IDLE.
- **RD_REQ.**
  - Drive `rw=0` and `user_addr`.
  - Assert `in_valid` for exactly one cycle, in the first cycle `busy==0`.
  - Go to `RD_WAIT` in the next cycle.
- **RD_WAIT.**
  - Ignore `out_valid` in the cycle immediately following the `in_valid` pulse.
  - On the first qualifying `out_valid`, latch `data_out` into the read buffer.
  - Plain read → `ACK`, with `wbs_dat_o` = buffer.
  - rmw → `MERGE`.
- **MERGE.** For each byte i, the merged byte i is `wbs_dat_i` byte i if `sel[i]`, else buffer byte i. The merged word goes to `data_in`. Go to `WR_REQ`.
- **WR_REQ.** Drive `rw=1` and `data_in`. Pulse `in_valid` in the first cycle `busy==0`, then → `ACK`. No completion is awaited, because the controller queues the write.
- **ACK.** Assert `wbs_ack_o` for one cycle only if `wbs_cyc_i` is still high, then → `IDLE`.
- **Master drops cyc mid-operation.** The SDRAM access in flight completes, no ack is issued, and any buffered read data is discarded.
- **Reset mid-operation.** The FSM returns to IDLE with `in_valid` low. The controller is reset by the same `rst`.
- **Idle defaults.** `in_valid`, `wbs_ack_o` and `rw` are 0 whenever they are not explicitly asserted.

## Timing
- **Reset values:** `wbs_ack_o=0`, `wbs_dat_o=0`, `in_valid=0`, `rw=0`, `user_addr=0`, `data_in=0`.
- **Outputs are registered.**
  - `in_valid` rises the cycle after the FSM enters a REQ state with `busy` sampled low.
  - `busy` high holds the request with no pulse and no timeout.
- **Full write:** capture at T0, `in_valid` at T1 (busy low), `wbs_ack_o` at T2. Latency is 3 cycles from stb to ack.
- **Read:** `wbs_ack_o` is asserted the cycle after the accepted `out_valid`, and `wbs_dat_o` is valid in that same cycle.
- **Partial write:** read latency plus 1 cycle for `MERGE` plus write issue.
- **Back-to-back:** a new capture is permitted the cycle after `ACK`. Minimum spacing is 1 idle cycle.
- **Simultaneous `out_valid` and `busy` high:** the data is still accepted, because `out_valid` has priority.

## Structure
- Shared package `sdram_bridge_pkg`:
  - state encoding (`IDLE`..`ACK`, 3 bits);
  - default `BASE_ADDR` and `ADDR_MASK`;
  - byte-merge function `merge_bytes(old, new, sel)`.
- Single module with no sub-module. The FSM and datapath together are about 200 lines.

## Test plan
- **Full write:** write `0x3800_0010` ← `0xA5A5_1234`, `sel=F` → one `in_valid` with `rw=1`, `user_addr=0x000010`, `data_in=0xA5A5_1234`; ack at T2.
- **Read:** read `0x3800_0010` with the controller model returning `0xA5A5_1234` after 6 cycles → `wbs_dat_o=0xA5A5_1234` with ack the cycle after `out_valid`.
- **RMW:** memory holds `0x1122_3344`; write `0xAABB_CCDD` with `sel=4'b0101` → read issued, then write `data_in=0x11BB_33DD`; a single ack.
- **Busy stall:** hold `busy=1` for 20 cycles during `RD_REQ` → no `in_valid` while busy; exactly one pulse after release.
- **Window miss:** access `0x3000_0000` → no `in_valid` and no ack for 50 cycles.
- **Cycle abort:** deassert `wbs_cyc_i` in `RD_WAIT` → the read completes, there is no ack, and the next transaction behaves normally. Reset asserted mid-`WR_REQ` → `in_valid=0` and state IDLE on the next cycle.
